sequential_multiplier: RTL and testbench

Parameterised sequential shift-and-add multiplier: the multi-cycle successor to the team's 4-bit combinational array multiplier. It computes an N×N → 2N product over N clock cycles using one N-bit adder instead of an N² array. Per-operation unsigned or signed (two's complement) mode, and a start/busy/done handshake so a controller can issue back-to-back operations.

---
 rtl/multiplier_pkg.sv | 15 +
 rtl/sequential_multiplier_if.sv | 22 ++
 rtl/seq_mult_datapath.sv | 66 ++++++
 rtl/sequential_multiplier.sv | 87 ++++++++
 tb/tb_sequential_multiplier.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/multiplier_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
package multiplier_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_e;

    // Iteration counter must hold the value WIDTH itself.
    function automatic int unsigned count_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/sequential_multiplier_if.sv
// Request/result bundle between a controller and the sequential multiplier.
interface sequential_multiplier_if #(
    parameter int unsigned WIDTH = 4
);
    logic                 start;
    logic                 is_signed;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   p;

    modport master (
        output start, is_signed, a, b,
        input  busy, done, p
    );

    modport slave (
        input  start, is_signed, a, b,
        output busy, done, p
    );
endinterface

// File: rtl/seq_mult_datapath.sv
// Accumulator, multiplier shift register, N+1-bit adder and final sign fix-up.
module seq_mult_datapath
    import multiplier_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_i,
    input  logic                 step_i,
    input  logic                 finish_i,
    input  logic                 is_signed_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic [2*WIDTH-1:0]   p_o
);
    localparam int unsigned PW = 2 * WIDTH;

    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [PW-1:0]    acc_q;
    logic [PW-1:0]    p_q;
    logic             neg_q;

    logic [WIDTH-1:0] a_mag_d;
    logic [WIDTH-1:0] b_mag_d;
    logic             neg_d;
    logic [WIDTH:0]   sum_d;
    logic [PW-1:0]    acc_d;

    // Magnitudes on load; one add-then-shift step per iteration.
    always_comb begin
        a_mag_d = (is_signed_i && a_i[WIDTH-1]) ? WIDTH'(-a_i) : a_i;
        b_mag_d = (is_signed_i && b_i[WIDTH-1]) ? WIDTH'(-b_i) : b_i;
        neg_d   = is_signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
        sum_d   = {1'b0, acc_q[PW-1:WIDTH]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
        acc_d   = PW'({sum_d, acc_q[WIDTH-1:0]} >> 1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            p_q      <= '0;
        end else begin
            if (load_i) begin
                mcand_q  <= a_mag_d;
                mplier_q <= b_mag_d;
                acc_q    <= '0;
                neg_q    <= neg_d;
            end else if (step_i) begin
                acc_q    <= acc_d;
                mplier_q <= mplier_q >> 1;
            end
            // The last iteration's result goes straight to p, sign-corrected.
            if (finish_i) begin
                p_q <= neg_q ? PW'(-acc_d) : acc_d;
            end
        end
    end

    assign p_o = p_q;

endmodule

// File: rtl/sequential_multiplier.sv
// N x N -> 2N shift-and-add multiplier: control FSM and iteration counter.
module sequential_multiplier
    import multiplier_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sequential_multiplier_if.slave mul
);
    localparam int unsigned CW = count_width(WIDTH);

    state_e        state_q;
    state_e        state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          busy_q;
    logic          busy_d;
    logic          done_q;
    logic          done_d;
    logic          load_c;
    logic          step_c;
    logic          finish_c;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next state, counter and datapath strobes; start only matters when ready.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        load_c   = 1'b0;
        step_c   = 1'b0;
        finish_c = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (mul.start) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                    load_c  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                step_c = 1'b1;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_d == CW'(WIDTH)) begin
                    state_d  = DONE;
                    finish_c = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == BUSY);
        done_d = (state_d == DONE);
    end

    seq_mult_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (load_c),
        .step_i      (step_c),
        .finish_i    (finish_c),
        .is_signed_i (mul.is_signed),
        .a_i         (mul.a),
        .b_i         (mul.b),
        .p_o         (mul.p)
    );

    assign mul.busy = busy_q;
    assign mul.done = done_q;

endmodule

// File: tb/tb_sequential_multiplier.sv
// Self-checking bench: WIDTH=4 and WIDTH=8 instances against an arithmetic product model.
module tb_sequential_multiplier;

    logic clk = 1'b0;
    logic rst4_n;
    logic rst8_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    sequential_multiplier_if #(.WIDTH(4)) m4 ();
    sequential_multiplier_if #(.WIDTH(8)) m8 ();

    sequential_multiplier #(.WIDTH(4)) u4 (.clk(clk), .rst_n(rst4_n), .mul(m4));
    sequential_multiplier #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst8_n), .mul(m8));

    typedef struct {
        bit         s;
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] exp;
    } vec4_t;

    typedef struct {
        bit          s;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
    } vec8_t;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Product from integer arithmetic, truncated to 2w bits.
    function automatic logic [63:0] ref_prod(input int w, input logic [31:0] a,
                                             input logic [31:0] b, input bit s);
        longint x;
        longint y;
        longint r;
        logic [63:0] mask;
        mask = (64'h1 << w) - 64'h1;
        x = longint'(64'(a) & mask);
        y = longint'(64'(b) & mask);
        if (s && x >= (longint'(1) << (w - 1))) x = x - (longint'(1) << w);
        if (s && y >= (longint'(1) << (w - 1))) y = y - (longint'(1) << w);
        r = x * y;
        return 64'(r) & ((64'h1 << (2 * w)) - 64'h1);
    endfunction

    // Waits for done on the 4-bit unit; busy must be high and p frozen until then.
    task automatic wait_done4(input logic [7:0] p_prev, output int n);
        bit seen;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (m4.done === 1'b1) begin
                seen = 1'b1;
                chk("busy_in_done", 64'(m4.busy), 64'd0);
            end else begin
                chk("busy_while_iter", 64'(m4.busy), 64'd1);
                chk("p_stable", 64'(m4.p), 64'(p_prev));
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout4: no done within %0d cycles", n);
        end
    endtask

    task automatic run4(input bit s, input logic [3:0] a, input logic [3:0] b,
                        input logic [7:0] exp, input string name);
        logic [7:0] p_prev;
        int n;
        p_prev = m4.p;
        m4.start = 1'b1; m4.is_signed = s; m4.a = a; m4.b = b;
        @(posedge clk); #1;
        m4.start = 1'b0;
        m4.a = 4'($urandom); m4.b = 4'($urandom); m4.is_signed = 1'($urandom);
        chk({name, "_busy"}, 64'(m4.busy), 64'd1);
        wait_done4(p_prev, n);
        chk({name, "_latency"}, 64'(n), 64'd4);
        chk({name, "_p"}, 64'(m4.p), 64'(exp));
        @(posedge clk); #1;
        chk({name, "_done_drop"}, 64'(m4.done), 64'd0);
    endtask

    task automatic run8(input bit s, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp, input string name);
        int n;
        m8.start = 1'b1; m8.is_signed = s; m8.a = a; m8.b = b;
        @(posedge clk); #1;
        m8.start = 1'b0;
        m8.a = 8'($urandom); m8.b = 8'($urandom); m8.is_signed = 1'($urandom);
        n = 0;
        while (m8.done !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_latency"}, 64'(n), 64'd8);
        chk({name, "_p"}, 64'(m8.p), 64'(exp));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec4_t tab4[10];
        vec8_t tab8[6];
        int n;
        int spurious;
        logic [7:0] p_prev;

        tab4[0] = '{1'b0, 4'd3,  4'd2,  8'd6};
        tab4[1] = '{1'b0, 4'd15, 4'd15, 8'd225};
        tab4[2] = '{1'b0, 4'd9,  4'd0,  8'd0};
        tab4[3] = '{1'b1, 4'hD,  4'd5,  8'hF1};
        tab4[4] = '{1'b1, 4'h8,  4'h8,  8'h40};
        tab4[5] = '{1'b1, 4'h8,  4'h7,  8'hC8};
        tab4[6] = '{1'b1, 4'hF,  4'hF,  8'h01};
        tab4[7] = '{1'b0, 4'h8,  4'h8,  8'h40};
        tab4[8] = '{1'b1, 4'h7,  4'h7,  8'h31};
        tab4[9] = '{1'b1, 4'hF,  4'h1,  8'hFF};

        tab8[0] = '{1'b0, 8'hFF, 8'hFF, 16'd65025};
        tab8[1] = '{1'b1, 8'h80, 8'h80, 16'h4000};
        tab8[2] = '{1'b1, 8'h80, 8'h7F, 16'hC080};
        tab8[3] = '{1'b1, 8'hFF, 8'hFF, 16'h0001};
        tab8[4] = '{1'b0, 8'h80, 8'h80, 16'h4000};
        tab8[5] = '{1'b1, 8'hFF, 8'h01, 16'hFFFF};

        rst4_n = 1'b0; rst8_n = 1'b0;
        m4.start = 1'b0; m4.is_signed = 1'b0; m4.a = '0; m4.b = '0;
        m8.start = 1'b0; m8.is_signed = 1'b0; m8.a = '0; m8.b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy4", 64'(m4.busy), 64'd0);
        chk("rst_done4", 64'(m4.done), 64'd0);
        chk("rst_p4",    64'(m4.p),    64'd0);
        chk("rst_busy8", 64'(m8.busy), 64'd0);
        chk("rst_p8",    64'(m8.p),    64'd0);
        rst4_n = 1'b1; rst8_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            run4(tab4[i].s, tab4[i].a, tab4[i].b, tab4[i].exp, $sformatf("vec4_%0d", i));
        end

        // Back-to-back with start held: 12x11, 4x9, 8x7.
        p_prev = m4.p;
        m4.start = 1'b1; m4.is_signed = 1'b0; m4.a = 4'd12; m4.b = 4'd11;
        @(posedge clk); #1;
        m4.a = 4'd4; m4.b = 4'd9;
        wait_done4(p_prev, n);
        chk("b2b_lat1", 64'(n), 64'd4);
        chk("b2b_p1", 64'(m4.p), 64'd132);
        @(posedge clk); #1;
        m4.a = 4'd8; m4.b = 4'd7;
        chk("b2b_busy2", 64'(m4.busy), 64'd1);
        wait_done4(8'd132, n);
        chk("b2b_period2", 64'(n + 1), 64'd5);
        chk("b2b_p2", 64'(m4.p), 64'd36);
        @(posedge clk); #1;
        m4.start = 1'b0;
        chk("b2b_busy3", 64'(m4.busy), 64'd1);
        wait_done4(8'd36, n);
        chk("b2b_period3", 64'(n + 1), 64'd5);
        chk("b2b_p3", 64'(m4.p), 64'd56);
        @(posedge clk); #1;
        chk("b2b_idle_busy", 64'(m4.busy), 64'd0);
        chk("b2b_idle_done", 64'(m4.done), 64'd0);

        // Start pulse during BUSY must be ignored.
        p_prev = m4.p;
        m4.start = 1'b1; m4.a = 4'd12; m4.b = 4'd11;
        @(posedge clk); #1;
        m4.start = 1'b0;
        @(posedge clk); #1;
        m4.start = 1'b1; m4.a = 4'd1; m4.b = 4'd1;
        @(posedge clk); #1;
        m4.start = 1'b0;
        wait_done4(p_prev, n);
        chk("ign_latency", 64'(n + 2), 64'd4);
        chk("ign_p", 64'(m4.p), 64'd132);
        @(posedge clk); #1;
        chk("ign_single_done", 64'(m4.done), 64'd0);
        chk("ign_idle", 64'(m4.busy), 64'd0);

        // Reset in the second BUSY cycle discards the operation.
        m4.start = 1'b1; m4.a = 4'd12; m4.b = 4'd11;
        @(posedge clk); #1;
        m4.start = 1'b0;
        @(posedge clk); #1;
        rst4_n = 1'b0;
        @(posedge clk); #1;
        rst4_n = 1'b1;
        chk("mid_rst_busy", 64'(m4.busy), 64'd0);
        chk("mid_rst_done", 64'(m4.done), 64'd0);
        chk("mid_rst_p", 64'(m4.p), 64'd0);
        spurious = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (m4.done !== 1'b0 || m4.busy !== 1'b0) spurious++;
        end
        chk("mid_rst_quiet", 64'(spurious), 64'd0);
        run4(1'b0, 4'd3, 4'd2, 8'd6, "post_rst");

        for (int i = 0; i < 200; i++) begin
            logic [3:0] ra;
            logic [3:0] rb;
            bit rs;
            ra = 4'($urandom); rb = 4'($urandom); rs = 1'($urandom);
            run4(rs, ra, rb, 8'(ref_prod(4, 32'(ra), 32'(rb), rs)), "rand4");
        end

        for (int i = 0; i < 6; i++) begin
            run8(tab8[i].s, tab8[i].a, tab8[i].b, tab8[i].exp, $sformatf("vec8_%0d", i));
        end

        for (int i = 0; i < 3000; i++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            bit rs;
            ra = 8'($urandom); rb = 8'($urandom); rs = (i % 2) == 1;
            run8(rs, ra, rb, 16'(ref_prod(8, 32'(ra), 32'(rb), rs)), "rand8");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
